// File: rtl/uart_tx_if.sv
// uart_tx_if: byte handshake between a data source and the UART transmitter.
//   tx_byte  - byte to send, sampled only on a handshake
//   tx_valid - tx_byte is valid
//   tx_ready - transmitter holding register is empty
// A byte transfers in any cycle where tx_valid && tx_ready at the rising edge.
interface uart_tx_if;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_byte,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_byte,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter with a one-entry holding register.
// Bytes arrive over a valid/ready handshake and are serialised LSB-first on tx_o.
// A byte queued during a frame starts on the cycle after the final stop bit,
// so frames can run back-to-back with no idle gap.
//
// Ports:
//   clk    - system clock, rising edge
//   rst    - asynchronous active-high reset; aborts any frame in progress
//   bus    - slave side of the byte handshake (tx_byte, tx_valid, tx_ready)
//   tx_o   - registered serial line, idles high
//   busy_o - a frame is in progress or the holding register is full
//   done_o - one-cycle pulse aligned with the last tx_o cycle of a frame's final stop bit
module uart_tx #(
  parameter int unsigned CLK_PER_BAUD = 4,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic      clk,
  input  logic      rst,
  uart_tx_if.slave  bus,
  output logic      tx_o,
  output logic      busy_o,
  output logic      done_o
);

  localparam int unsigned CntW = (CLK_PER_BAUD > 1) ? $clog2(CLK_PER_BAUD) : 1;
  localparam logic [CntW-1:0] CntMax  = CntW'(CLK_PER_BAUD - 1);
  localparam logic [2:0]      StopMax = 3'(STOP_BITS - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;     // data bit index in StData, stop bit index in StStop
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      hold_q, hold_d;
  logic            hold_full_q, hold_full_d;
  logic            ready_q;
  logic            tx_q, tx_d;
  logic            done_q, done_d;
  logic            load;
  logic            wrap;
  logic            accept;

  assign wrap   = (cnt_q == CntMax);
  // ready_q is registered, so acceptance never depends combinationally on tx_valid
  assign accept = bus.tx_valid && ready_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = wrap ? '0 : cnt_q + 1'b1;
    idx_d       = idx_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    tx_d        = 1'b1;
    done_d      = 1'b0;
    load        = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (hold_full_q) load = 1'b1;
      end
      StStart: begin
        tx_d = 1'b0;
        if (wrap) begin
          state_d = StData;
          idx_d   = '0;
        end
      end
      StData: begin
        tx_d = shift_q[idx_q];
        if (wrap) begin
          if (idx_q == 3'd7) begin
            state_d = StStop;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      StStop: begin
        if (wrap) begin
          if (idx_q == StopMax) begin
            done_d = 1'b1;
            // A queued byte starts straight away: zero idle gap between frames
            if (hold_full_q) load = 1'b1;
            else             state_d = StIdle;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      shift_d     = hold_q;
      hold_full_d = 1'b0;
      state_d     = StStart;
      cnt_d       = '0;
      idx_d       = '0;
    end

    // Never coincides with load: accept needs an empty holding register
    if (accept) begin
      hold_d      = bus.tx_byte;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      ready_q     <= 1'b0;
      tx_q        <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      ready_q     <= !hold_full_d;
      tx_q        <= tx_d;
      done_q      <= done_d;
    end
  end

  assign bus.tx_ready = ready_q;
  assign tx_o         = tx_q;
  assign done_o       = done_q;
  assign busy_o       = (state_q != StIdle) || hold_full_q;

endmodule
